// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size encodings,
// FSM states and the default data-memory depth.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEPTH_DEFAULT = 10001;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: extract and extend sub-word loads, and merge
// sub-word store data into the word read back from memory.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rd_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (off)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = rd_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // funct3[0] separates halfword stores from byte stores
  always_comb begin
    merged = rd_word;
    if (funct3[0]) begin
      if (off[1]) merged[31:16] = wdata;
      else        merged[15:0]  = wdata;
    end else begin
      case (off)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data memory. Sub-word stores run
// as a two-cycle read-modify-write that stalls the core for one cycle.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             misaligned,
  output logic             fault,
  output logic [31:0]      mem_A,
  output logic             mem_WE,
  output logic [31:0]      mem_WD,
  input  logic [31:0]      mem_RD,
  output logic [CNT_W-1:0] rmw_count
);

  state_t      state, state_nxt;
  logic [31:0] lat_idx, lat_word;
  logic [31:0] widx;
  logic [1:0]  off;
  logic        mis_raw, flt_raw;
  logic [31:0] load_data, merged;

  assign widx = {2'b00, req_addr[31:2]};
  assign off  = req_addr[1:0];

  lsu_lane u_lane (
    .funct3    (req_funct3),
    .off       (off),
    .rd_word   (mem_RD),
    .wdata     (req_wdata[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    case (req_funct3)
      F3_H, F3_HU: mis_raw = off[0];
      F3_W:        mis_raw = |off;
      default:     mis_raw = 1'b0;
    endcase
    flt_raw = (widx >= 32'(DEPTH)) || (req_funct3 == 3'b011) ||
              (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
  end

  // Outputs are forced quiet while rst is high so a held store cannot write
  always_comb begin
    state_nxt  = state;
    mem_A      = widx;
    mem_WE     = 1'b0;
    mem_WD     = req_wdata;
    rdata      = 32'h0;
    stall      = 1'b0;
    misaligned = 1'b0;
    fault      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            misaligned = mis_raw;
            fault      = !mis_raw && flt_raw;
            if (!mis_raw && !flt_raw) begin
              if (!req_we) begin
                rdata = load_data;
              end else if (req_funct3 == F3_W) begin
                mem_WE = 1'b1;
              end else begin
                stall     = 1'b1;
                state_nxt = WRITE;
              end
            end
          end
        end
        WRITE: begin
          mem_A     = lat_idx;
          mem_WD    = lat_word;
          mem_WE    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_idx   <= 32'h0;
      lat_word  <= 32'h0;
      rmw_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == WRITE) begin
        lat_idx  <= widx;
        lat_word <= merged;
      end
      if (state == WRITE) begin
        rmw_count <= rmw_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a small word-indexed memory model.
module tb_lsu_rmw;
  import lsu_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;
  logic        stall, misaligned, fault, mem_WE;
  logic [31:0] rmw_count;

  logic [31:0] mem [0:10000];
  logic        pre_en;
  logic [13:0] pre_idx;
  logic [31:0] pre_data;

  int checks_total;
  int checks_passed;

  lsu_rmw #(.DEPTH(10001), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .fault      (fault),
    .mem_A      (mem_A),
    .mem_WE     (mem_WE),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD),
    .rmw_count  (rmw_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_RD = (mem_A < 32'd10001) ? mem[mem_A[13:0]] : 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_WE && mem_A < 32'd10001) mem[mem_A[13:0]] <= mem_WD;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    else
      checks_passed++;
  endtask

  task automatic applyStimulus(input logic valid, input logic we,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = valid;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b0;
    pre_en    = 1'b1;
    pre_idx   = idx;
    pre_data  = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pre_en     = 1'b0;
    pre_idx    = 14'h0;
    pre_data   = 32'h0;

    // Mid-cycle reset pulse with a word store presented: nothing may write
    #7;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_funct3 = F3_W;
    req_addr  = 32'h14;
    req_wdata = 32'h1234_5678;
    #1;
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_stall", {31'h0, stall}, 32'h0);
    checkOutput("rst_we", {31'h0, mem_WE}, 32'h0);
    checkOutput("rst_count", rmw_count, 32'h0);
    checkOutput("rst_mis", {31'h0, misaligned}, 32'h0);
    checkOutput("rst_fault", {31'h0, fault}, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;

    preload(14'd5, 32'h8081_7F02);
    preload(14'd10, 32'h0);

    // Load formatting from word 5 = 0x8081_7F02
    applyStimulus(1'b1, 1'b0, F3_B, 32'h15, 32'h0);
    checkOutput("lb_15", rdata, 32'h0000_007F);
    checkOutput("lb_15_A", mem_A, 32'd5);
    applyStimulus(1'b1, 1'b0, F3_B, 32'h16, 32'h0);
    checkOutput("lb_16", rdata, 32'hFFFF_FF81);
    checkOutput("lb_stall", {31'h0, stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, F3_BU, 32'h16, 32'h0);
    checkOutput("lbu_16", rdata, 32'h0000_0081);
    applyStimulus(1'b1, 1'b0, F3_H, 32'h16, 32'h0);
    checkOutput("lh_16", rdata, 32'hFFFF_8081);
    applyStimulus(1'b1, 1'b0, F3_HU, 32'h16, 32'h0);
    checkOutput("lhu_16", rdata, 32'h0000_8081);
    applyStimulus(1'b1, 1'b0, F3_H, 32'h14, 32'h0);
    checkOutput("lh_14", rdata, 32'h0000_7F02);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
    checkOutput("lw_14", rdata, 32'h8081_7F02);
    checkOutput("lw_stall", {31'h0, stall}, 32'h0);
    checkOutput("lw_we", {31'h0, mem_WE}, 32'h0);

    // SW writes in the same cycle
    applyStimulus(1'b1, 1'b1, F3_W, 32'h28, 32'hDEAD_BEEF);
    checkOutput("sw_we", {31'h0, mem_WE}, 32'h1);
    checkOutput("sw_A", mem_A, 32'd10);
    checkOutput("sw_WD", mem_WD, 32'hDEAD_BEEF);
    checkOutput("sw_stall", {31'h0, stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    checkOutput("sw_mem", mem[10], 32'hDEAD_BEEF);

    // SB @0x29 over 0xDEAD_BEEF: two cycles, lane 1 replaced
    applyStimulus(1'b1, 1'b1, F3_B, 32'h29, 32'h0000_00AA);
    checkOutput("sb_c1_stall", {31'h0, stall}, 32'h1);
    checkOutput("sb_c1_we", {31'h0, mem_WE}, 32'h0);
    checkOutput("sb_c1_A", mem_A, 32'd10);
    applyStimulus(1'b1, 1'b1, F3_B, 32'h29, 32'h0000_00AA);
    checkOutput("sb_c2_we", {31'h0, mem_WE}, 32'h1);
    checkOutput("sb_c2_WD", mem_WD, 32'hDEAD_AAEF);
    checkOutput("sb_c2_A", mem_A, 32'd10);
    checkOutput("sb_c2_stall", {31'h0, stall}, 32'h0);
    checkOutput("sb_c2_cnt", rmw_count, 32'd0);
    applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    checkOutput("sb_cnt", rmw_count, 32'd1);
    checkOutput("sb_mem", mem[10], 32'hDEAD_AAEF);

    // SH @0x2A then SB @0x28 back-to-back over 0x1122_3344
    preload(14'd10, 32'h1122_3344);
    applyStimulus(1'b1, 1'b1, F3_H, 32'h2A, 32'h0000_BEEF);
    checkOutput("b2b_c1_stall", {31'h0, stall}, 32'h1);
    applyStimulus(1'b1, 1'b1, F3_H, 32'h2A, 32'h0000_BEEF);
    checkOutput("b2b_c2_stall", {31'h0, stall}, 32'h0);
    checkOutput("b2b_c2_WD", mem_WD, 32'hBEEF_3344);
    applyStimulus(1'b1, 1'b1, F3_B, 32'h28, 32'h0000_00CC);
    checkOutput("b2b_c3_stall", {31'h0, stall}, 32'h1);
    checkOutput("b2b_c3_we", {31'h0, mem_WE}, 32'h0);
    applyStimulus(1'b1, 1'b1, F3_B, 32'h28, 32'h0000_00CC);
    checkOutput("b2b_c4_stall", {31'h0, stall}, 32'h0);
    checkOutput("b2b_c4_WD", mem_WD, 32'hBEEF_33CC);
    applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    checkOutput("b2b_mem", mem[10], 32'hBEEF_33CC);
    checkOutput("b2b_cnt", rmw_count, 32'd3);

    // Alignment and range checks: no write, no stall
    applyStimulus(1'b1, 1'b0, F3_W, 32'h22, 32'h0);
    checkOutput("lw22_mis", {31'h0, misaligned}, 32'h1);
    checkOutput("lw22_rdata", rdata, 32'h0);
    applyStimulus(1'b1, 1'b1, F3_H, 32'h21, 32'h0000_5555);
    checkOutput("sh21_mis", {31'h0, misaligned}, 32'h1);
    checkOutput("sh21_we", {31'h0, mem_WE}, 32'h0);
    checkOutput("sh21_stall", {31'h0, stall}, 32'h0);
    applyStimulus(1'b1, 1'b1, F3_W, 32'h9C44, 32'h0000_1111);
    checkOutput("sw_oob_fault", {31'h0, fault}, 32'h1);
    checkOutput("sw_oob_we", {31'h0, mem_WE}, 32'h0);
    applyStimulus(1'b1, 1'b1, F3_W, 32'h9C40, 32'h0);
    checkOutput("sw_last_fault", {31'h0, fault}, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h14, 32'h0);
    checkOutput("f3_011_fault", {31'h0, fault}, 32'h1);
    checkOutput("f3_011_rdata", rdata, 32'h0);
    applyStimulus(1'b1, 1'b1, F3_H, 32'h9C45, 32'h0);
    checkOutput("prio_mis", {31'h0, misaligned}, 32'h1);
    checkOutput("prio_fault", {31'h0, fault}, 32'h0);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h28, 32'h0);
    checkOutput("after_chk_rdata", rdata, 32'hBEEF_33CC);
    checkOutput("after_chk_cnt", rmw_count, 32'd3);

    // Reset during WRITE drops mem_WE immediately and discards the write
    applyStimulus(1'b1, 1'b1, F3_B, 32'h28, 32'h0000_0055);
    checkOutput("rw_c1_stall", {31'h0, stall}, 32'h1);
    applyStimulus(1'b1, 1'b1, F3_B, 32'h28, 32'h0000_0055);
    checkOutput("rw_c2_we", {31'h0, mem_WE}, 32'h1);
    checkOutput("rw_c2_cnt", rmw_count, 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rw_rst_we", {31'h0, mem_WE}, 32'h0);
    checkOutput("rw_rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, F3_W, 32'h28, 32'h0);
    checkOutput("rw_mem", mem[10], 32'hBEEF_33CC);
    checkOutput("rw_rdata", rdata, 32'hBEEF_33CC);
    checkOutput("rw_idle_stall", {31'h0, stall}, 32'h0);
    checkOutput("rw_idle_we", {31'h0, mem_WE}, 32'h0);
    checkOutput("rw_cnt", rmw_count, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
